// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the PWM compare slice.
package pwm_pkg;

   localparam int PWM_WIDTH_DEF = 32'sd3;
   localparam int PWM_DEAD_DEF  = 32'sd1;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 32'sd0;
      v   = value - 32'sd1;
      while (v > 32'sd0) begin
         res = res + 32'sd1;
         v   = v >>> 1;
      end
      return res;
   endfunction

   // Width that holds the values 0..dead inclusive.
   function automatic int dt_width(input int dead);
      return clog2(dead + 32'sd1);
   endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Complementary output stage with dead-time insertion; used only when PWM_COMPL_EN is defined.
// Takes the next raw level so the counter reloads on the same edge at which the raw level flips.
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int DEAD_CYC = PWM_DEAD_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic raw_d_i,
   output logic pwm_o,
   output logic pwm_n_o
);

   localparam int              DT_W    = dt_width(DEAD_CYC);
   localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_CYC);
   localparam logic [DT_W-1:0] DT_ZERO = {DT_W{1'b0}};

   logic            raw_q;
   logic [DT_W-1:0] dt_q;
   logic [DT_W-1:0] dt_d;
   logic            pwm_q;
   logic            pwm_n_q;

   // Restart the dead-time window on every raw transition, otherwise run down to zero.
   always_comb begin
      dt_d = dt_q;
      if (raw_d_i != raw_q) begin
         dt_d = DT_LOAD;
      end else if (dt_q != DT_ZERO) begin
         dt_d = dt_q - DT_W'(1);
      end else begin
         dt_d = dt_q;
      end
   end

   // Raw level, dead-time counter and the gated output pair.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         raw_q   <= 1'b0;
         dt_q    <= DT_LOAD;
         pwm_q   <= 1'b0;
         pwm_n_q <= 1'b0;
      end else begin
         raw_q   <= raw_d_i;
         dt_q    <= dt_d;
         pwm_q   <= raw_d_i & (dt_d == DT_ZERO);
         pwm_n_q <= ~raw_d_i & (dt_d == DT_ZERO);
      end
   end

   assign pwm_o   = pwm_q;
   assign pwm_n_o = pwm_n_q;

endmodule

// File: rtl/pwm_compare.sv
// PWM comparator with wrap detection and a shadowed duty register loaded at counter wrap.
// Define PWM_COMPL_EN to add the complementary output pwm_n_o with dead-time.
module pwm_compare
   import pwm_pkg::*;
#(
   parameter int               WIDTH    = PWM_WIDTH_DEF,
   parameter logic [WIDTH-1:0] DUTY_RST = {WIDTH{1'b0}},
   parameter int               DEAD_CYC = PWM_DEAD_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] cnt_i,
   input  logic [WIDTH-1:0] duty_i,
   input  logic             duty_valid_i,
   output logic             duty_ready_o,
   output logic             pwm_o,
   output logic             wrap_o
`ifdef PWM_COMPL_EN
   ,
   output logic             pwm_n_o
`endif
);

   logic [WIDTH-1:0] cnt_prev_q;
   logic [WIDTH-1:0] shadow_q;
   logic [WIDTH-1:0] shadow_d;
   logic [WIDTH-1:0] active_q;
   logic [WIDTH-1:0] active_d;
   logic             pending_q;
   logic             pending_d;
   logic             wrap_q;
   logic             wrap_s;
   logic             accept_s;
   logic             raw_d;

   // A drop in count is a wrap, whether a natural roll-over or a counter reset mid-period.
   assign wrap_s   = (cnt_i < cnt_prev_q);
   assign accept_s = duty_valid_i & ~pending_q;

   // Wrap with a pending shadow promotes it; an accept can only coincide with an empty shadow.
   always_comb begin
      shadow_d  = shadow_q;
      active_d  = active_q;
      pending_d = pending_q;
      if (wrap_s && pending_q) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end else if (accept_s) begin
         shadow_d  = duty_i;
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end
      raw_d = (cnt_i < active_d);
   end

   // Handshake, duty and wrap state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_prev_q <= {WIDTH{1'b0}};
         shadow_q   <= {WIDTH{1'b0}};
         active_q   <= DUTY_RST;
         pending_q  <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         cnt_prev_q <= cnt_i;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         pending_q  <= pending_d;
         wrap_q     <= wrap_s;
      end
   end

   assign duty_ready_o = ~pending_q;
   assign wrap_o       = wrap_q;

`ifdef PWM_COMPL_EN
   pwm_deadtime #(
      .DEAD_CYC (DEAD_CYC)
   ) u_deadtime (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .raw_d_i (raw_d),
      .pwm_o   (pwm_o),
      .pwm_n_o (pwm_n_o)
   );
`else
   logic raw_q;
   logic dead_cyc_unused_s;

   assign dead_cyc_unused_s = ^DEAD_CYC;

   // Plain registered compare result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         raw_q <= 1'b0;
      end else begin
         raw_q <= raw_d;
      end
   end

   assign pwm_o = raw_q;
`endif

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare driven by a free-running 3-bit counter.
module tb_pwm_compare;

   localparam int DEAD = 1;
`ifdef PWM_COMPL_EN
   localparam int ADJ = 1;
`else
   localparam int ADJ = 0;
`endif

   logic       clk_i        = 1'b0;
   logic       rst_ni       = 1'b0;
   logic [2:0] cnt_i        = 3'd0;
   logic [2:0] duty_i       = 3'd0;
   logic       duty_valid_i = 1'b0;
   logic       duty_ready_o;
   logic       pwm_o;
   logic       wrap_o;
   logic       pwm_n_o;
`ifndef PWM_COMPL_EN
   assign pwm_n_o = 1'b0;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   logic acc_flag   = 1'b0;
   logic force_zero = 1'b0;
   logic hold_cnt   = 1'b0;

   always #5 clk_i = ~clk_i;

   pwm_compare #(
      .WIDTH    (3),
      .DUTY_RST (3'd0),
      .DEAD_CYC (DEAD)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .cnt_i        (cnt_i),
      .duty_i       (duty_i),
      .duty_valid_i (duty_valid_i),
      .duty_ready_o (duty_ready_o),
      .pwm_o        (pwm_o),
      .wrap_o       (wrap_o)
`ifdef PWM_COMPL_EN
      ,
      .pwm_n_o      (pwm_n_o)
`endif
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_high(input int d);
      return (d == 0) ? 0 : d - ADJ;
   endfunction

   // Reference model: duty takes effect at the wrap after it is accepted.
   initial begin : model
      int   q[$];
      int   active, prev, age, c, d;
      logic v, r, w, acc, raw_m, new_raw, e_p, e_n;
      active = 0; prev = 0; age = 0; raw_m = 1'b0;
      forever begin
         @(posedge clk_i);
         c = int'(cnt_i); d = int'(duty_i); v = duty_valid_i; r = rst_ni;
         #1;
         if (!r) begin
            q.delete();
            active = 0; prev = 0; age = 0; raw_m = 1'b0;
            chk1("rst_pwm", pwm_o, 1'b0);
            chk1("rst_pwm_n", pwm_n_o, 1'b0);
            chk1("rst_wrap", wrap_o, 1'b0);
            chk1("rst_ready", duty_ready_o, 1'b1);
         end else begin
            w   = (c < prev);
            acc = v && (q.size() == 0);
            if (w && q.size() > 0) active = q.pop_front();
            if (acc) q.push_back(d);
            prev    = c;
            new_raw = (c < active);
            if (new_raw != raw_m) age = 0;
            else if (age < 1000) age++;
            raw_m = new_raw;
            e_p = raw_m;
            e_n = 1'b0;
            if (ADJ != 0) begin
               e_p = raw_m && (age >= DEAD);
               e_n = !raw_m && (age >= DEAD);
            end
            chk1("pwm", pwm_o, e_p);
            chk1("pwm_n", pwm_n_o, e_n);
            chk1("wrap", wrap_o, w);
            chk1("ready", duty_ready_o, q.size() == 0);
            chk1("not_both_high", pwm_o & pwm_n_o, 1'b0);
         end
      end
   end

   task automatic tick();
      @(negedge clk_i);
      if (duty_valid_i && acc_flag) duty_valid_i = 1'b0;
      if (!rst_ni) begin
         cnt_i = 3'd0;
      end else if (force_zero) begin
         cnt_i = 3'd0;
         force_zero = 1'b0;
      end else if (hold_cnt) begin
         hold_cnt = 1'b0;
      end else begin
         cnt_i = cnt_i + 3'd1;
      end
      acc_flag = duty_valid_i && duty_ready_o;
   endtask

   task automatic offer(input int d);
      duty_i       = 3'(d);
      duty_valid_i = 1'b1;
      acc_flag     = duty_ready_o;
   endtask

   task automatic wait_accept();
      int g = 0;
      while (duty_valid_i && g < 40) begin
         tick();
         g++;
      end
      chk1("accept_timeout", duty_valid_i, 1'b0);
   endtask

   task automatic wait_cnt(input int v);
      int g = 0;
      while (int'(cnt_i) != v && g < 20) begin
         tick();
         g++;
      end
      chki("cnt_reach", int'(cnt_i), v);
   endtask

   // Counts output highs and wrap pulses over one 8-cycle period starting at a wrap.
   task automatic measure(output int highs, output int highs_n, output int wraps);
      int g = 0;
      highs = 0; highs_n = 0; wraps = 0;
      while (wrap_o !== 1'b1 && g < 40) begin
         tick();
         g++;
      end
      chk1("wrap_seen", wrap_o, 1'b1);
      for (int i = 0; i < 8; i++) begin
         highs   += int'(pwm_o);
         highs_n += int'(pwm_n_o);
         wraps   += int'(wrap_o);
         tick();
      end
   endtask

   initial begin : stim
      int h, hn, wr;
      repeat (3) tick();
      rst_ni = 1'b1;

      measure(h, hn, wr);
      chki("reset_duty0_high", h, 0);
      measure(h, hn, wr);
      chki("reset_duty0_high2", h, 0);

      wait_cnt(4);
      offer(3);
      tick();
      chk1("load_ready_low", duty_ready_o, 1'b0);
      measure(h, hn, wr);
      chki("load3_high", h, exp_high(3));
      chki("load3_wraps", wr, 1);
      chk1("load_ready_back", duty_ready_o, 1'b1);

      offer(2);
      wait_accept();
      offer(5);
      tick();
      chk1("bp_held_valid", duty_valid_i, 1'b1);
      chk1("bp_ready_low", duty_ready_o, 1'b0);
      measure(h, hn, wr);
      chki("bp_first_period", h, exp_high(2));
      measure(h, hn, wr);
      chki("bp_second_period", h, exp_high(5));

      offer(6);
      wait_accept();
      wait_cnt(5);
      force_zero = 1'b1;
      tick();
      measure(h, hn, wr);
      chki("cntrst_high", h, exp_high(6));
      chki("cntrst_wraps", wr, 1);

      offer(0);
      wait_accept();
      measure(h, hn, wr);
      chki("duty0_high", h, 0);
      offer(7);
      wait_accept();
      measure(h, hn, wr);
      chki("duty7_high", h, exp_high(7));
      chki("duty7_wraps", wr, 1);

      offer(4);
      wait_accept();
      measure(h, hn, wr);
      chki("duty4_high", h, exp_high(4));
`ifdef PWM_COMPL_EN
      chki("duty4_high_n", hn, 3);
`endif

      wait_cnt(3);
      offer(2);
      wait_cnt(5);
      rst_ni = 1'b0;
      #1;
      chk1("midrst_pwm", pwm_o, 1'b0);
      chk1("midrst_wrap", wrap_o, 1'b0);
      chk1("midrst_ready", duty_ready_o, 1'b1);
      duty_valid_i = 1'b0;
      acc_flag     = 1'b0;
      repeat (3) tick();
      rst_ni = 1'b1;
      measure(h, hn, wr);
      chki("midrst_after_high", h, 0);

      for (int i = 0; i < 600; i++) begin
         tick();
         if (!duty_valid_i && $urandom_range(0, 3) == 0) offer(int'($urandom_range(0, 7)));
         if ($urandom_range(0, 49) == 0) force_zero = 1'b1;
         else if ($urandom_range(0, 39) == 0) hold_cnt = 1'b1;
      end
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
